rx_protocol: RTL and testbench
==============================

Name: rx_protocol

Overview:
- Serial receive side of the TX/RX link: the receiver paired with the existing transmit protocol block.
- Hunts the 1-bit line for the 6-bit start sequence, shifts in a 55-bit payload MSB-first, then checks the trailing 0 stop bit.
- Presents the assembled word with a sticky ready flag that the router-side consumer clears.
- Sits between the serial wire and the router's packet input.

Parameters:
- sz_START_SEQ, 6, start sequence length in bits
- sz_DATA, 55, payload length in bits
- START_SEQ, 6'b01_1111, start pattern; on the wire the MSB arrives first (0,1,1,1,1,1)

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
- S_Data  in  1  serial line, sampled once per clk
- clr_rdy  in  1  consumer acknowledge; clears rdy and overrun
- RX_Data  out  55  last good payload; bit 54 is the first payload bit received
- rdy  out  1  high while RX_Data holds an unacknowledged good frame
- frm_err  out  1  one-cycle pulse on a bad stop bit
- overrun  out  1  sticky; a good frame completed while rdy was still set

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=HUNT; seq_sr, data_sr, counter, RX_Data, rdy, frm_err and overrun are all 0.
  - Reset mid-frame abandons the frame with no outputs raised.
- States: HUNT, RECEIVE, STOP.
- HUNT:
  - Each cycle, seq_sr <= {seq_sr[4:0], S_Data}.
  - If {seq_sr[4:0], S_Data} == START_SEQ, go to RECEIVE and set counter = sz_DATA.
  - A non-0/1 (X) line value never matches.
- RECEIVE:
  - Each cycle, data_sr <= {data_sr[53:0], S_Data} and counter decrements.
  - When counter == 1 (the 55th bit is sampled this cycle), go to STOP.
  - Start patterns embedded in the payload are ignored.
- STOP (stop bit sampled this cycle):
  - S_Data==0 (good frame): RX_Data <= data_sr; rdy <= 1. If rdy==1 and clr_rdy==0 this cycle, overrun <= 1.
  - S_Data!=0 (bad frame): frm_err=1 for exactly one cycle; RX_Data, rdy and overrun are unchanged.
  - Always return to HUNT with seq_sr cleared to 0, so a fresh 6 sampled bits are needed before the next detection.
- Latency: if the last start bit is sampled at edge N, payload bits are sampled at edges N+1..N+55 and the stop bit at N+56. rdy and RX_Data are valid after edge N+56.
- clr_rdy: at the next edge, rdy <= 0 and overrun <= 0. Exception: if clr_rdy coincides with a good STOP, rdy stays 1 (new data) and overrun stays 0.
- Back-to-back frames: the earliest next start bit is sampled the cycle after STOP. The receiver accepts this, and at least one idle cycle is also tolerated.
- Counter width: 6 bits, sufficient for 55; no wrap, since it is reloaded on every HUNT→RECEIVE transition.
- Outputs are registered, except the next_state/next_counter logic.

Decomposition:
- Shared package (also imported by trans_protocol), containing:
  - sz_START_SEQ, sz_DATA, START_SEQ
  - RX state encodings
  - the stop-bit value constant (0)
- Optional sub-module start_seq_detector: shift register plus comparator with a clear input; outputs a match strobe. The main FSM, payload shifter and flag logic stay in rx_protocol.

Test Plan:
- Reset, then bits 0,1,1,1,1,1 followed by 55'h2A_AAAA_AAAA_AAAA MSB-first, then a 0 stop bit -> rdy=1 and RX_Data=55'h2A_AAAA_AAAA_AAAA after edge N+56; frm_err stays 0.
- Same frame with stop bit 1 -> frm_err pulses for one cycle; rdy=0 and RX_Data=0.
- Two good frames (payloads 55'h1, then 55'h7F_FFFF_FFFF_FFFF) with no clr_rdy between them -> after the second frame, RX_Data=55'h7F_FFFF_FFFF_FFFF and overrun=1. Then assert clr_rdy -> rdy=0 and overrun=0.
- Payload containing bit pattern 011111 (e.g. 55'h1F) -> the frame is received intact as 55'h1F; no resync mid-payload.
- clr_rdy asserted in the same cycle as the second frame's STOP -> rdy stays 1 and overrun=0.
- rst_n pulled low at payload bit 20, then a full good frame with payload 55'h5 -> no output from the aborted frame; RX_Data=55'h5 and rdy=1.

Source files
------------

// File: rtl/rx_protocol_pkg.sv
// Shared TX/RX link definitions: frame geometry, start pattern, stop-bit value and RX state encodings.
package rx_protocol_pkg;

  localparam int unsigned sz_START_SEQ = 6;
  localparam int unsigned sz_DATA      = 55;
  localparam int unsigned CNT_W        = 6;

  localparam logic [sz_START_SEQ-1:0] START_SEQ = 6'b01_1111;
  localparam logic                    STOP_BIT  = 1'b0;

  typedef logic [sz_DATA-1:0] rx_word_t;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    RECEIVE = 2'd1,
    STOP    = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_protocol_start_det.sv
// Start-sequence hunter: shifts the line while enabled and strobes when the last
// sz_START_SEQ samples (including the current one) equal START_SEQ.
module rx_protocol_start_det
  import rx_protocol_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic match_c
);

  logic [sz_START_SEQ-1:0] seq_sr;
  logic [sz_START_SEQ-1:0] seq_nxt_c;

  assign seq_nxt_c = {seq_sr[sz_START_SEQ-2:0], din};
  // An X on the line makes the compare X, which never counts as a match.
  assign match_c   = en && (seq_nxt_c == START_SEQ);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_sr <= '0;
    end else if (clr) begin
      seq_sr <= '0;
    end else if (en) begin
      seq_sr <= seq_nxt_c;
    end
  end

endmodule

// File: rtl/rx_protocol.sv
// Serial link receiver: hunts for the start pattern, shifts in the payload MSB-first,
// checks the stop bit and holds the word behind a sticky rdy flag.
module rx_protocol
  import rx_protocol_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               S_Data,
  input  logic               clr_rdy,
  output logic [sz_DATA-1:0] RX_Data,
  output logic               rdy,
  output logic               frm_err,
  output logic               overrun
);

  rx_state_e        state;
  rx_word_t         data_sr;
  logic [CNT_W-1:0] counter;
  logic             start_match_c;

  rx_protocol_start_det u_start_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state == HUNT),
    .clr     (state == STOP),
    .din     (S_Data),
    .match_c (start_match_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= HUNT;
      data_sr <= '0;
      counter <= '0;
      RX_Data <= '0;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      frm_err <= 1'b0;
      if (clr_rdy) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end

      case (state)
        HUNT: begin
          if (start_match_c) begin
            state   <= RECEIVE;
            counter <= CNT_W'(sz_DATA);
          end
        end

        RECEIVE: begin
          data_sr <= {data_sr[sz_DATA-2:0], S_Data};
          counter <= counter - CNT_W'(1);
          if (counter == CNT_W'(1)) begin
            state <= STOP;
          end
        end

        STOP: begin
          state <= HUNT;
          if (S_Data == STOP_BIT) begin
            // New data wins over a simultaneous acknowledge.
            RX_Data <= data_sr;
            rdy     <= 1'b1;
            if (rdy && !clr_rdy) begin
              overrun <= 1'b1;
            end
          end else begin
            frm_err <= 1'b1;
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_protocol.sv
// Directed self-checking bench for rx_protocol.
module tb_rx_protocol;

  logic        clk;
  logic        rst_n;
  logic        S_Data;
  logic        clr_rdy;
  logic [54:0] RX_Data;
  logic        rdy;
  logic        frm_err;
  logic        overrun;

  int errors;
  int checks;

  rx_protocol dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .S_Data  (S_Data),
    .clr_rdy (clr_rdy),
    .RX_Data (RX_Data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [54:0] got, input logic [54:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one line bit, let one rising edge sample it, settle past the edge.
  task automatic send_bit(input logic b);
    S_Data = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    S_Data = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Start pattern then payload MSB-first; the stop bit is sent by the caller.
  task automatic send_head(input logic [54:0] p);
    logic [5:0] sp;
    sp = 6'b011111;
    for (int i = 5; i >= 0; i--) send_bit(sp[i]);
    for (int i = 54; i >= 0; i--) send_bit(p[i]);
  endtask

  task automatic clear_ack();
    clr_rdy = 1'b1;
    send_bit(1'b0);
    clr_rdy = 1'b0;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    clr_rdy = 1'b0;
    S_Data  = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    check("rst_rdy", 55'(rdy), 55'd0);
    check("rst_data", RX_Data, 55'd0);
    check("rst_frm_err", 55'(frm_err), 55'd0);
    check("rst_overrun", 55'(overrun), 55'd0);
    send_bit(1'b0);
    send_bit(1'b0);

    // Good frame, alternating payload; rdy must not rise before the stop edge
    send_head(55'h2A_AAAA_AAAA_AAAA);
    check("t1_rdy_before_stop", 55'(rdy), 55'd0);
    send_bit(1'b0);
    check("t1_rdy", 55'(rdy), 55'd1);
    check("t1_data", RX_Data, 55'h2A_AAAA_AAAA_AAAA);
    check("t1_frm_err", 55'(frm_err), 55'd0);
    check("t1_overrun", 55'(overrun), 55'd0);
    clear_ack();
    check("t1_clr_rdy", 55'(rdy), 55'd0);
    check("t1_hold_data", RX_Data, 55'h2A_AAAA_AAAA_AAAA);

    // Bad stop bit after a fresh reset
    do_reset();
    send_head(55'h2A_AAAA_AAAA_AAAA);
    send_bit(1'b1);
    check("t2_frm_err", 55'(frm_err), 55'd1);
    check("t2_rdy", 55'(rdy), 55'd0);
    check("t2_data", RX_Data, 55'd0);
    send_bit(1'b0);
    check("t2_frm_err_pulse", 55'(frm_err), 55'd0);

    // Two good frames back-to-back without acknowledge
    do_reset();
    send_head(55'h1);
    send_bit(1'b0);
    check("t3a_data", RX_Data, 55'h1);
    check("t3a_overrun", 55'(overrun), 55'd0);
    send_head(55'h7F_FFFF_FFFF_FFFF);
    send_bit(1'b0);
    check("t3b_data", RX_Data, 55'h7F_FFFF_FFFF_FFFF);
    check("t3b_rdy", 55'(rdy), 55'd1);
    check("t3b_overrun", 55'(overrun), 55'd1);
    clear_ack();
    check("t3_clr_rdy", 55'(rdy), 55'd0);
    check("t3_clr_overrun", 55'(overrun), 55'd0);

    // Embedded start pattern in payload must not resync
    send_head(55'h1F);
    send_bit(1'b0);
    check("t4_data", RX_Data, 55'h1F);
    check("t4_rdy", 55'(rdy), 55'd1);
    check("t4_frm_err", 55'(frm_err), 55'd0);
    send_bit(1'b0);

    // Unacknowledged frame sets overrun; next frame's stop coincides with clr_rdy
    send_head(55'h3);
    send_bit(1'b0);
    check("t5a_data", RX_Data, 55'h3);
    check("t5a_overrun", 55'(overrun), 55'd1);
    send_head(55'h12_3456_789A_BCDE);
    clr_rdy = 1'b1;
    send_bit(1'b0);
    clr_rdy = 1'b0;
    check("t5b_data", RX_Data, 55'h12_3456_789A_BCDE);
    check("t5b_rdy", 55'(rdy), 55'd1);
    check("t5b_overrun", 55'(overrun), 55'd0);

    // Reset at payload bit 20, then a clean frame
    begin
      logic [5:0] sp;
      logic [54:0] p;
      sp = 6'b011111;
      p  = 55'h2A_AAAA_AAAA_AAAA;
      for (int i = 5; i >= 0; i--) send_bit(sp[i]);
      for (int i = 54; i > 34; i--) send_bit(p[i]);
    end
    rst_n  = 1'b0;
    S_Data = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("t6_rst_rdy", 55'(rdy), 55'd0);
    check("t6_rst_data", RX_Data, 55'd0);
    check("t6_rst_overrun", 55'(overrun), 55'd0);
    for (int i = 0; i < 60; i++) begin
      send_bit(1'b0);
    end
    check("t6_idle_rdy", 55'(rdy), 55'd0);
    check("t6_idle_frm_err", 55'(frm_err), 55'd0);
    send_head(55'h5);
    send_bit(1'b0);
    check("t6_data", RX_Data, 55'h5);
    check("t6_rdy", 55'(rdy), 55'd1);
    check("t6_overrun", 55'(overrun), 55'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
